adc_capture: RTL and testbench

- Acquisition front end for the AD9280-class 8-bit parallel ADC. It is the capture-side counterpart of the ROM-driven DA output path.
- Drives the ADC sample clock and registers incoming samples. Optionally decimates, waits for a level/edge trigger, then writes a fixed-length record into a single-port buffer RAM through a write port.
- Software-facing start/busy/done handshake. Sits between the ADC pins and the capture RAM that downstream logic (display/UART dump) reads.

---
 rtl/adc_capture_pkg.sv | 16 +
 rtl/adc_trig_detect.sv | 43 ++++
 rtl/adc_capture.sv | 158 +++++++++++++++
 tb/tb_adc_capture.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types and defaults for the ADC capture slice.
// No logic: state encoding and width defaults only.
// Nothing here carries flow control.
package adc_capture_pkg;

  localparam int ADC_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } cap_state_e;

endpackage

// File: rtl/adc_trig_detect.sv
// Level-crossing trigger: remembers the previous kept sample and flags a crossing.
// Latency: hit is combinational from stb/sample; prev updates on the next edge.
// No backpressure: evaluates only on cycles where stb and enable are both high.
module adc_trig_detect
  import adc_capture_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  input  logic              stb,
  input  logic              edge_sel,
  input  logic [DATA_W-1:0] level,
  input  logic [DATA_W-1:0] sample,
  output logic              hit
);

  logic [DATA_W-1:0] prev;
  logic              prev_valid;
  logic              rise_x;
  logic              fall_x;

  // Equality belongs to the post-crossing side only.
  assign rise_x = (prev < level) && (sample >= level);
  assign fall_x = (prev > level) && (sample <= level);
  assign hit    = enable && stb && prev_valid && (edge_sel ? fall_x : rise_x);

  // Track the last kept sample; the first one after arming only seeds prev.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (clear) begin
      prev_valid <= 1'b0;
    end else if (enable && stb && !hit) begin
      prev       <= sample;
      prev_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/adc_capture.sv
// ADC capture: registers AD9280 samples, decimates, triggers, writes one record to RAM.
// Latency: pin to wr_data 2 cycles; done rises the cycle after the last write.
// No backpressure: the RAM write port always accepts; start is ignored while busy.
module adc_capture
  import adc_capture_pkg::*;
#(
  parameter int DATA_W  = ADC_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DECIM_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               trig_en,
  input  logic               trig_edge,
  input  logic [DATA_W-1:0]  trig_level,
  input  logic [DECIM_W-1:0] decim,
  output logic               ad_clk,
  input  logic [DATA_W-1:0]  ad_data,
  input  logic               ad_otr,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic               busy,
  output logic               done,
  output logic               otr_seen
);

  localparam logic [ADDR_W-1:0]  ADDR_LAST = '1;
  localparam logic [ADDR_W-1:0]  ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DECIM_W-1:0] DEC_ONE   = {{(DECIM_W-1){1'b0}}, 1'b1};

  cap_state_e         state;
  logic [DATA_W-1:0]  s_q;
  logic               o_q;
  logic               trig_en_q;
  logic               trig_edge_q;
  logic [DATA_W-1:0]  level_q;
  logic [DECIM_W-1:0] decim_q;
  logic [DECIM_W-1:0] dec_cnt;
  logic               running;
  logic               accept;
  logic               stb;
  logic               hit;
  logic               arm_write;
  logic [ADDR_W-1:0]  next_addr;

  // ADC samples on the opposite edge so data is stable at our rising edge.
  assign ad_clk    = ~clk;

  assign running   = (state == ARM) || (state == CAPT);
  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign stb       = running && (dec_cnt == decim_q);
  assign arm_write = (state == ARM) && stb && (!trig_en_q || hit);
  assign next_addr = wr_addr + ADDR_ONE;

  // Input stage: register the ADC pins once per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
      o_q <= 1'b0;
    end else begin
      s_q <= ad_data;
      o_q <= ad_otr;
    end
  end

  // Latch the capture controls only when a start is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_en_q   <= 1'b0;
      trig_edge_q <= 1'b0;
      level_q     <= '0;
      decim_q     <= '0;
    end else if (accept) begin
      trig_en_q   <= trig_en;
      trig_edge_q <= trig_edge;
      level_q     <= trig_level;
      decim_q     <= decim;
    end
  end

  // Decimator: one strobe every decim_q+1 cycles while armed or capturing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt <= '0;
    end else if (accept) begin
      dec_cnt <= '0;
    end else if (running) begin
      dec_cnt <= (dec_cnt == decim_q) ? '0 : dec_cnt + DEC_ONE;
    end
  end

  adc_trig_detect #(
    .DATA_W(DATA_W)
  ) u_trig (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .enable  ((state == ARM) && trig_en_q),
    .stb     (stb),
    .edge_sel(trig_edge_q),
    .level   (level_q),
    .sample  (s_q),
    .hit     (hit)
  );

  // Capture sequencer with registered write port and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      otr_seen <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= ARM;
            busy     <= 1'b1;
            done     <= 1'b0;
            otr_seen <= 1'b0;
            wr_addr  <= '0;
          end else if (state == DONE) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        ARM: begin
          if (arm_write) begin
            wr_en    <= 1'b1;
            wr_addr  <= '0;
            wr_data  <= s_q;
            otr_seen <= o_q;
            state    <= CAPT;
          end
        end
        CAPT: begin
          if (stb) begin
            wr_en    <= 1'b1;
            wr_addr  <= next_addr;
            wr_data  <= s_q;
            otr_seen <= otr_seen | o_q;
            if (next_addr == ADDR_LAST) begin
              state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_capture.sv
module tb_adc_capture;

  localparam int DW   = 8;
  localparam int AW   = 4;
  localparam int DCW  = 8;
  localparam int LEN  = 16;
  localparam int MAXC = 128;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           trig_en = 1'b0;
  logic           trig_edge = 1'b0;
  logic [DW-1:0]  trig_level = '0;
  logic [DCW-1:0] decim = '0;
  logic [DW-1:0]  ad_data = '0;
  logic           ad_otr = 1'b0;
  logic           ad_clk;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic           busy;
  logic           done;
  logic           otr_seen;

  always #15 clk = ~clk;

  adc_capture #(.DATA_W(DW), .ADDR_W(AW), .DECIM_W(DCW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .trig_en(trig_en),
    .trig_edge(trig_edge), .trig_level(trig_level), .decim(decim),
    .ad_clk(ad_clk), .ad_data(ad_data), .ad_otr(ad_otr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .otr_seen(otr_seen)
  );

  // Per-edge stimulus: values present at the rising edge of cycle c.
  logic [7:0] s_d[MAXC], s_lvl[MAXC], s_dec[MAXC];
  logic       s_o[MAXC], s_st[MAXC], s_rn[MAXC], s_te[MAXC], s_ted[MAXC];
  // Expected outputs just after the rising edge of cycle c.
  logic       e_wren[MAXC], e_busy[MAXC], e_done[MAXC], e_otr[MAXC];
  logic [3:0] e_addr[MAXC];
  logic [7:0] e_data[MAXC];

  int vecs = 0;
  int miss = 0;
  int n_wr, first_wr, first_done, first_otr, prev_wr, min_gap, max_gap;
  logic [7:0] first_data, last_data;
  logic end_busy, end_otr;

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Controls default to junk so only values latched at start can matter.
  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      s_d[c] = 8'h00; s_o[c] = 1'b0; s_st[c] = 1'b0;
      s_rn[c] = (c < 2) ? 1'b0 : 1'b1;
      s_te[c] = 1'b1; s_ted[c] = 1'b1; s_lvl[c] = 8'hA5; s_dec[c] = 8'd2;
    end
  endtask

  task automatic ramp();
    for (int c = 0; c < MAXC; c++) s_d[c] = 8'(c);
  endtask

  task automatic arm_at(input int c, input logic te, input logic ted,
                        input logic [7:0] lvl, input logic [7:0] dec);
    s_st[c] = 1'b1; s_te[c] = te; s_ted[c] = ted; s_lvl[c] = lvl; s_dec[c] = dec;
  endtask

  // Value held in the input register after edge c (cleared while in reset).
  function automatic logic [7:0] pin_d(input int c);
    if (c < 0) return 8'h00;
    return s_rn[c] ? s_d[c] : 8'h00;
  endfunction

  function automatic logic pin_o(input int c);
    if (c < 0) return 1'b0;
    return s_rn[c] ? s_o[c] : 1'b0;
  endfunction

  // Record model: from each accepted start, walk the kept-sample stream,
  // find the trigger point and lay out LEN writes on the strobe edges.
  task automatic build_expect(input int n);
    int pos;
    int k;
    int per;
    int nw;
    int t;
    logic hold_done, hold_otr, fire, have_prev, otr;
    logic [7:0] prev, smp, lvl;
    for (int c = 0; c < MAXC; c++) begin
      e_wren[c] = 0; e_busy[c] = 0; e_done[c] = 0; e_otr[c] = 0;
      e_addr[c] = 0; e_data[c] = 0;
    end
    pos = 0; hold_done = 0; hold_otr = 0;
    while (pos < n) begin
      if (!s_rn[pos]) begin
        hold_done = 0; hold_otr = 0; pos++;
      end else if (!s_st[pos]) begin
        e_done[pos] = hold_done; e_otr[pos] = hold_otr; pos++;
      end else begin
        k = pos; per = int'(s_dec[k]) + 1; lvl = s_lvl[k];
        fire = !s_te[k]; have_prev = 0; prev = 0; nw = 0; otr = 0;
        e_busy[k] = 1;
        t = k + 1;
        while (t < n && s_rn[t] && nw < LEN) begin
          e_busy[t] = 1; e_otr[t] = otr;
          if ((t - k) % per == 0) begin
            smp = pin_d(t - 1);
            if (!fire) begin
              if (have_prev && (s_ted[k] ? (prev > lvl && smp <= lvl)
                                         : (prev < lvl && smp >= lvl)))
                fire = 1;
              else begin
                prev = smp; have_prev = 1;
              end
            end
            if (fire) begin
              e_wren[t] = 1; e_addr[t] = 4'(nw); e_data[t] = smp;
              otr = otr | pin_o(t - 1); e_otr[t] = otr;
              nw++;
            end
          end
          t++;
        end
        hold_done = (nw == LEN); hold_otr = otr; pos = t;
      end
    end
  endtask

  // Drive each cycle on the falling edge, compare #1 after the rising edge.
  task automatic run(input int n, input string tag);
    n_wr = 0; first_wr = -1; first_done = -1; first_otr = -1; prev_wr = -1;
    min_gap = 1000; max_gap = 0; first_data = 0; last_data = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rst_n = s_rn[c]; start = s_st[c]; trig_en = s_te[c]; trig_edge = s_ted[c];
      trig_level = s_lvl[c]; decim = s_dec[c]; ad_data = s_d[c]; ad_otr = s_o[c];
      if (!s_rn[c]) begin
        #1;
        chk($sformatf("%s c%0d async_clear", tag, c), {wr_en, busy, done, otr_seen}, 0);
      end
      @(posedge clk);
      #1;
      chk($sformatf("%s c%0d ad_clk", tag, c), ad_clk, !clk);
      chk($sformatf("%s c%0d wr_en", tag, c), wr_en, e_wren[c]);
      chk($sformatf("%s c%0d busy", tag, c), busy, e_busy[c]);
      chk($sformatf("%s c%0d done", tag, c), done, e_done[c]);
      chk($sformatf("%s c%0d otr_seen", tag, c), otr_seen, e_otr[c]);
      if (e_wren[c] || !s_rn[c]) begin
        chk($sformatf("%s c%0d wr_addr", tag, c), wr_addr, e_addr[c]);
        chk($sformatf("%s c%0d wr_data", tag, c), wr_data, e_data[c]);
      end
      if (wr_en) begin
        if (first_wr < 0) begin first_wr = c; first_data = wr_data; end
        if (prev_wr >= 0) begin
          if (c - prev_wr < min_gap) min_gap = c - prev_wr;
          if (c - prev_wr > max_gap) max_gap = c - prev_wr;
        end
        prev_wr = c; last_data = wr_data; n_wr++;
      end
      if (done && first_done < 0) first_done = c;
      if (otr_seen && first_otr < 0) first_otr = c;
      end_busy = busy; end_otr = otr_seen;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    // Free-run ramp, no decimation, no trigger.
    clear_stim(); ramp(); arm_at(4, 0, 0, 8'h00, 8'd0);
    build_expect(26); run(26, "free");
    chk("free n_wr", n_wr, 16);
    chk("free first_wr_cycle", first_wr, 5);
    chk("free first_data", first_data, 4);
    chk("free last_data", last_data, 19);
    chk("free first_done", first_done, 21);

    // Decimate by 4.
    clear_stim(); ramp(); arm_at(4, 0, 0, 8'h00, 8'd3);
    build_expect(72); run(72, "decim");
    chk("decim n_wr", n_wr, 16);
    chk("decim first_data", first_data, 7);
    chk("decim last_data", last_data, 67);
    chk("decim min_gap", min_gap, 4);
    chk("decim max_gap", max_gap, 4);
    chk("decim first_done", first_done, 69);

    // Rising trigger, then re-arm on a flat input that never crosses.
    clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      if (c < 6) s_d[c] = 8'h10;
      else if (c == 6) s_d[c] = 8'h70;
      else if (c == 7) s_d[c] = 8'h7F;
      else if (c == 8) s_d[c] = 8'h80;
      else if (c < 26) s_d[c] = 8'(8'h90 + c - 9);
      else s_d[c] = 8'h80;
    end
    arm_at(4, 1, 0, 8'h80, 8'd0); arm_at(30, 1, 0, 8'h80, 8'd0);
    build_expect(60); run(60, "rise");
    chk("rise first_wr_cycle", first_wr, 9);
    chk("rise first_data", first_data, 8'h80);
    chk("rise last_data", last_data, 8'h9E);
    chk("rise n_wr", n_wr, 16);
    chk("rise end_busy", end_busy, 1);

    // Falling trigger, then a rising input that must not fire.
    clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      if (c < 8) s_d[c] = 8'h50;
      else if (c == 8) s_d[c] = 8'h40;
      else if (c < 28) s_d[c] = 8'(8'h41 + c - 9);
      else if (c < 35) s_d[c] = 8'h30;
      else s_d[c] = 8'h50;
    end
    arm_at(4, 1, 1, 8'h40, 8'd0); arm_at(30, 1, 1, 8'h40, 8'd0);
    build_expect(60); run(60, "fall");
    chk("fall first_wr_cycle", first_wr, 9);
    chk("fall first_data", first_data, 8'h40);
    chk("fall n_wr", n_wr, 16);
    chk("fall end_busy", end_busy, 1);

    // Start during capture is ignored; reset at write 5 aborts; restart is clean.
    clear_stim(); ramp(); arm_at(4, 0, 0, 8'h00, 8'd0);
    s_st[8] = 1'b1;
    s_rn[10] = 1'b0; s_rn[11] = 1'b0;
    arm_at(14, 0, 0, 8'h00, 8'd0);
    build_expect(40); run(40, "abort");
    chk("abort n_wr", n_wr, 21);
    chk("abort last_data", last_data, 29);
    chk("abort first_done", first_done, 31);

    // Out-of-range flag during capture: sticky until the next start.
    clear_stim(); ramp(); arm_at(4, 0, 0, 8'h00, 8'd0);
    s_o[10] = 1'b1;
    arm_at(26, 0, 0, 8'h00, 8'd0);
    build_expect(32); run(32, "otr");
    chk("otr first_set_cycle", first_otr, 11);
    chk("otr cleared_by_start", end_otr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
